// File: rtl/rmii_phy_loopback.sv
// RMII PHY-side loopback: captures one MAC frame from TXD/TX_EN into a byte
// buffer and replays it byte-exact on RXD/CRS_DV after an inter-frame gap.
module rmii_phy_loopback #(
    parameter bit RATE_10_100 = 1'b1,
    parameter int ADDR_W      = 11,
    parameter int IFG_CYCLES  = 48
) (
    input  logic              ref_clk,
    input  logic              reset_n,
    input  logic [1:0]        mac_txd,
    input  logic              mac_tx_en,
    input  logic              loop_en,
    input  logic              inject_er,
    output logic [1:0]        phy_rxd,
    output logic              phy_crs_dv,
    output logic              phy_rx_er,
    output logic              busy,
    output logic [ADDR_W:0]   frame_len,
    output logic              frame_done,
    output logic              ovf,
    output logic              trunc
);
    localparam int AW1 = ADDR_W + 1;
    localparam int GW  = $clog2(IFG_CYCLES);
    localparam logic [ADDR_W:0] DEPTH = AW1'(1) << ADDR_W;

    typedef enum logic [2:0] {IDLE, CAPTURE, DROP, GAP, REPLAY} state_t;
    state_t state;

    logic              tx_en_q;
    logic [3:0]        phase_q, phase_cur;
    logic              rise, tick, hold_done;
    logic [1:0]        cnt;
    logic [5:0]        sh;
    logic [ADDR_W:0]   wr_ptr, rptr;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rdata, cur, wdata;
    logic [1:0]        rdib;
    logic [3:0]        hcnt;
    logic              inj, we;
    logic [GW-1:0]     gcnt;
    logic [7:0]        mem [2**ADDR_W];

    // 10M: the phase restarts on the TX_EN edge so sampling lands mid-dibit.
    assign rise      = mac_tx_en & ~tx_en_q;
    assign phase_cur = rise ? 4'd0 : phase_q;
    assign tick      = RATE_10_100 ? 1'b1 : (phase_cur == 4'd5);
    assign hold_done = RATE_10_100 ? 1'b1 : (hcnt == 4'd9);
    assign we        = (state == CAPTURE) && tick && mac_tx_en && (cnt == 2'd3) && (wr_ptr != DEPTH);
    assign wdata     = {mac_txd, sh};

    // raddr idles at 0, so byte 0 is already sitting in rdata when GAP ends.
    always_ff @(posedge ref_clk) begin
        if (we) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
        rdata <= mem[raddr];
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_en_q    <= 1'b1;
            phase_q    <= '0;
            cnt        <= '0;
            sh         <= '0;
            wr_ptr     <= '0;
            rptr       <= '0;
            raddr      <= '0;
            cur        <= '0;
            rdib       <= '0;
            hcnt       <= '0;
            inj        <= 1'b0;
            gcnt       <= '0;
            phy_rxd    <= '0;
            phy_crs_dv <= 1'b0;
            phy_rx_er  <= 1'b0;
            busy       <= 1'b0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
            trunc      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            ovf        <= 1'b0;
            trunc      <= 1'b0;
            tx_en_q    <= mac_tx_en;
            phase_q    <= (phase_cur == 4'd9) ? 4'd0 : phase_cur + 4'd1;
            case (state)
                IDLE: if (rise && loop_en) begin
                    state  <= CAPTURE;
                    busy   <= 1'b1;
                    inj    <= inject_er;
                    wr_ptr <= '0;
                    cnt    <= '0;
                    if (tick) begin
                        sh  <= {mac_txd, sh[5:2]};
                        cnt <= 2'd1;
                    end
                end
                CAPTURE: if (tick) begin
                    if (!mac_tx_en) begin
                        trunc     <= (cnt != 2'd0);
                        frame_len <= wr_ptr;
                        gcnt      <= '0;
                        if (wr_ptr == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (cnt == 2'd3) begin
                        cnt <= '0;
                        if (wr_ptr == DEPTH) begin
                            ovf   <= 1'b1;
                            state <= DROP;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end else begin
                        sh  <= {mac_txd, sh[5:2]};
                        cnt <= cnt + 2'd1;
                    end
                end
                DROP: if (!mac_tx_en) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                GAP: if (gcnt == GW'(IFG_CYCLES - 2)) begin
                    state      <= REPLAY;
                    cur        <= rdata;
                    phy_rxd    <= rdata[1:0];
                    phy_crs_dv <= 1'b1;
                    phy_rx_er  <= 1'b0;
                    rptr       <= '0;
                    rdib       <= '0;
                    hcnt       <= '0;
                    raddr      <= ADDR_W'(1);
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                REPLAY: if (hold_done) begin
                    hcnt <= '0;
                    if (rdib != 2'd3) begin
                        phy_rxd <= cur[{rdib + 2'd1, 1'b0} +: 2];
                        rdib    <= rdib + 2'd1;
                    end else if (rptr == frame_len - 1'b1) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        phy_rxd    <= '0;
                        phy_crs_dv <= 1'b0;
                        phy_rx_er  <= 1'b0;
                        frame_done <= 1'b1;
                        raddr      <= '0;
                    end else begin
                        cur       <= rdata;
                        phy_rxd   <= rdata[1:0];
                        rdib      <= '0;
                        rptr      <= rptr + 1'b1;
                        raddr     <= raddr + 1'b1;
                        phy_rx_er <= inj && (rptr == AW1'(7));
                    end
                end else begin
                    hcnt <= hcnt + 4'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rmii_phy_loopback.sv
// Bench for rmii_phy_loopback: a 100M and a 10M instance, a per-cycle expected
// timeline built from frame-level rules, plus literal spot checks.
module tb_rmii_phy_loopback;
    localparam int NCYC = 16000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] txd [2];
    logic       tx_en [2], loop_en [2], inj_er [2];
    logic [1:0] rxd [2];
    logic       crs [2], rx_er [2], busy [2], done [2], ovf [2], trunc [2];
    logic [6:0] len0;
    logic [4:0] len1;

    rmii_phy_loopback #(.RATE_10_100(1'b1), .ADDR_W(6), .IFG_CYCLES(48)) u_fast (
        .ref_clk(clk), .reset_n(reset_n), .mac_txd(txd[0]), .mac_tx_en(tx_en[0]),
        .loop_en(loop_en[0]), .inject_er(inj_er[0]), .phy_rxd(rxd[0]), .phy_crs_dv(crs[0]),
        .phy_rx_er(rx_er[0]), .busy(busy[0]), .frame_len(len0), .frame_done(done[0]),
        .ovf(ovf[0]), .trunc(trunc[0]));

    rmii_phy_loopback #(.RATE_10_100(1'b0), .ADDR_W(4), .IFG_CYCLES(12)) u_slow (
        .ref_clk(clk), .reset_n(reset_n), .mac_txd(txd[1]), .mac_tx_en(tx_en[1]),
        .loop_en(loop_en[1]), .inject_er(inj_er[1]), .phy_rxd(rxd[1]), .phy_crs_dv(crs[1]),
        .phy_rx_er(rx_er[1]), .busy(busy[1]), .frame_len(len1), .frame_done(done[1]),
        .ovf(ovf[1]), .trunc(trunc[1]));

    // expected value of every output in every clock period
    bit         e_crs [2][NCYC], e_er [2][NCYC], e_busy [2][NCYC];
    bit         e_done [2][NCYC], e_ovf [2][NCYC], e_trunc [2][NCYC];
    logic [1:0] e_rxd [2][NCYC];
    int         e_len [2][NCYC];

    int         cyc, total, bad;
    int         idle_at [2];
    logic [1:0] fr [$];
    logic [1:0] rxq [$];
    int         crs_cnt [2], er_cnt [2], done_cnt [2], ovf_cnt [2], trunc_cnt [2];
    int         first_crs [2], first_er [2];
    bit         crs_prev [2], er_prev [2];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, act, exp);
        end
    endtask

    // compare at the negedge of the current period, then advance one clock
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("crs_dv", d, crs[d], e_crs[d][cyc]);
            chk("rxd", d, rxd[d], e_rxd[d][cyc]);
            chk("rx_er", d, rx_er[d], e_er[d][cyc]);
            chk("busy", d, busy[d], e_busy[d][cyc]);
            chk("frame_done", d, done[d], e_done[d][cyc]);
            chk("ovf", d, ovf[d], e_ovf[d][cyc]);
            chk("trunc", d, trunc[d], e_trunc[d][cyc]);
            chk("frame_len", d, (d == 0) ? 32'(len0) : 32'(len1), e_len[d][cyc]);
            if (crs[d] === 1'b1) begin
                crs_cnt[d]++;
                if (!crs_prev[d]) first_crs[d] = cyc;
                if (d == 1) rxq.push_back(rxd[1]);
            end
            if (rx_er[d] === 1'b1) begin
                er_cnt[d]++;
                if (!er_prev[d]) first_er[d] = cyc;
            end
            crs_prev[d] = (crs[d] === 1'b1);
            er_prev[d]  = (rx_er[d] === 1'b1);
            if (done[d] === 1'b1)  done_cnt[d]++;
            if (ovf[d] === 1'b1)   ovf_cnt[d]++;
            if (trunc[d] === 1'b1) trunc_cnt[d]++;
        end
        if (cyc >= NCYC - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [1:0] q_at(input int i);
        return (i < rxq.size()) ? rxq[i] : 2'bxx;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) fr.push_back(b[2*k +: 2]);
    endtask

    // frame-level rules: what the PHY must emit for the dibits in fr sent from period s
    task automatic predict(input int d, input int s, input bit inj);
        int h, off, depth, ifg, nd, nb, z, e, c;
        h = d ? 10 : 1;  off = d ? 5 : 0;  depth = d ? 16 : 64;  ifg = d ? 12 : 48;
        nd = fr.size();  nb = nd / 4;
        if (nb > depth) begin
            c = s + h * (4 * depth + 3) + off + 1;
            if (c < NCYC) e_ovf[d][c] = 1'b1;
            for (c = s + 1; c <= s + h * nd && c < NCYC; c++) e_busy[d][c] = 1'b1;
            idle_at[d] = s + h * nd + 1;
        end else begin
            z = s + h * nd + off;
            if (nd % 4 != 0 && z + 1 < NCYC) e_trunc[d][z + 1] = 1'b1;
            for (c = z + 1; c < NCYC; c++) e_len[d][c] = nb;
            e = (nb == 0) ? z + 1 : z + ifg + 4 * nb * h;
            for (c = s + 1; c < e && c < NCYC; c++) e_busy[d][c] = 1'b1;
            if (nb > 0) begin
                for (int j = 0; j < 4 * nb; j++)
                    for (int k = 0; k < h; k++) begin
                        c = z + ifg + j * h + k;
                        if (c < NCYC) begin
                            e_crs[d][c] = 1'b1;
                            e_rxd[d][c] = fr[j];
                            e_er[d][c]  = inj && (nb > 8) && (j / 4 == 8);
                        end
                    end
                if (e < NCYC) e_done[d][e] = 1'b1;
            end
            idle_at[d] = e;
        end
    endtask

    // drive fr; inject/loop_en are flipped after the first clock to show they are start-sampled
    task automatic send(input int d, input bit inj, input bit le, input bit pred);
        int h;
        h = d ? 10 : 1;
        if (pred) predict(d, cyc, inj);
        tx_en[d] = 1'b1;  inj_er[d] = inj;  loop_en[d] = le;
        for (int j = 0; j < fr.size(); j++) begin
            txd[d] = fr[j];
            for (int k = 0; k < h; k++) begin
                step();
                inj_er[d] = !inj;  loop_en[d] = !le;
            end
        end
        tx_en[d] = 1'b0;  txd[d] = 2'b00;  inj_er[d] = 1'b0;  loop_en[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        while (cyc <= idle_at[d] + 2) step();
    endtask

    task automatic rand_bytes(input int n);
        fr.delete();
        for (int i = 0; i < n; i++) push_byte(8'($urandom));
    endtask

    initial begin
        int c0, o0, t0, d0, r0, b0, fall, nd;
        bit ri;
        total = 0;  bad = 0;  cyc = 0;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            txd[d] = 2'b00;  tx_en[d] = 1'b0;  loop_en[d] = 1'b0;  inj_er[d] = 1'b0;
        end
        @(posedge clk);  #1;  cyc = 1;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("reset_len", 0, len0, 0);
        chk("reset_busy", 1, busy[1], 0);

        // 10M single byte 0xB4: dibits 00,01,11,10, 10 clocks each
        fr.delete();  push_byte(8'hB4);
        b0 = rxq.size();  c0 = crs_cnt[1];
        send(1, 1'b0, 1'b1, 1'b1);  wait_idle(1);
        chk("b4_crs_clocks", 1, crs_cnt[1] - c0, 40);
        chk("b4_dibit0", 1, q_at(b0), 2'b00);
        chk("b4_dibit0_end", 1, q_at(b0 + 9), 2'b00);
        chk("b4_dibit1", 1, q_at(b0 + 10), 2'b01);
        chk("b4_dibit2", 1, q_at(b0 + 20), 2'b11);
        chk("b4_dibit3", 1, q_at(b0 + 39), 2'b10);
        chk("b4_len", 1, len1, 1);

        // 10M overflow of a 16-byte buffer
        rand_bytes(20);
        o0 = ovf_cnt[1];  c0 = crs_cnt[1];
        send(1, 1'b0, 1'b1, 1'b1);  wait_idle(1);
        chk("slow_ovf_pulses", 1, ovf_cnt[1] - o0, 1);
        chk("slow_ovf_no_replay", 1, crs_cnt[1] - c0, 0);
        chk("slow_ovf_len_kept", 1, len1, 1);

        // 10M error injection on a 12-byte frame
        rand_bytes(12);
        r0 = er_cnt[1];
        send(1, 1'b1, 1'b1, 1'b1);  wait_idle(1);
        chk("slow_er_clocks", 1, er_cnt[1] - r0, 40);
        chk("slow_er_offset", 1, first_er[1] - first_crs[1], 320);

        // 100M basic 64-byte frame
        fr.delete();
        for (int i = 0; i < 7; i++) push_byte(8'h55);
        push_byte(8'hD5);
        for (int i = 0; i < 56; i++) push_byte(8'($urandom));
        c0 = crs_cnt[0];  d0 = done_cnt[0];
        send(0, 1'b0, 1'b1, 1'b1);  fall = cyc;  wait_idle(0);
        chk("basic_gap", 0, first_crs[0] - fall, 48);
        chk("basic_crs_clocks", 0, crs_cnt[0] - c0, 256);
        chk("basic_len", 0, len0, 64);
        chk("basic_done", 0, done_cnt[0] - d0, 1);

        // 100M error injection: 64 bytes gets byte 8 flagged, 6 bytes does not
        rand_bytes(64);
        r0 = er_cnt[0];
        send(0, 1'b1, 1'b1, 1'b1);  wait_idle(0);
        chk("er_clocks", 0, er_cnt[0] - r0, 4);
        chk("er_offset", 0, first_er[0] - first_crs[0], 32);
        rand_bytes(6);
        r0 = er_cnt[0];
        send(0, 1'b1, 1'b1, 1'b1);  wait_idle(0);
        chk("er_short_none", 0, er_cnt[0] - r0, 0);

        // 10 dibits: partial byte dropped
        fr.delete();
        for (int i = 0; i < 10; i++) fr.push_back(2'($urandom));
        t0 = trunc_cnt[0];  c0 = crs_cnt[0];
        send(0, 1'b0, 1'b1, 1'b1);  wait_idle(0);
        chk("trunc_pulse", 0, trunc_cnt[0] - t0, 1);
        chk("trunc_len", 0, len0, 2);
        chk("trunc_crs_clocks", 0, crs_cnt[0] - c0, 8);

        // 100M overflow of a 64-byte buffer
        rand_bytes(66);
        o0 = ovf_cnt[0];  c0 = crs_cnt[0];
        send(0, 1'b0, 1'b1, 1'b1);  wait_idle(0);
        chk("ovf_pulse", 0, ovf_cnt[0] - o0, 1);
        chk("ovf_len_kept", 0, len0, 2);
        chk("ovf_no_replay", 0, crs_cnt[0] - c0, 0);

        // loop_en low at start: frame not captured
        rand_bytes(8);
        c0 = crs_cnt[0];
        send(0, 1'b0, 1'b0, 1'b0);
        repeat (80) step();
        chk("loop_off_no_replay", 0, crs_cnt[0] - c0, 0);
        chk("loop_off_len", 0, len0, 2);

        // a frame started during REPLAY is never replayed
        rand_bytes(40);
        c0 = crs_cnt[0];  d0 = done_cnt[0];
        send(0, 1'b0, 1'b1, 1'b1);
        repeat (60) step();
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(2'($urandom));
        send(0, 1'b0, 1'b1, 1'b0);
        wait_idle(0);
        repeat (100) step();
        chk("ignored_crs_clocks", 0, crs_cnt[0] - c0, 160);
        chk("ignored_done", 0, done_cnt[0] - d0, 1);

        // random frames, including partial bytes and injection
        for (int n = 0; n < 5; n++) begin
            nd = $urandom_range(1, 160);
            ri = 1'($urandom);
            fr.delete();
            for (int i = 0; i < nd; i++) fr.push_back(2'($urandom));
            send(0, ri, 1'b1, 1'b1);  wait_idle(0);
        end

        // reset in the middle of a replay
        rand_bytes(30);
        send(0, 1'b0, 1'b1, 1'b1);
        repeat (68) step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_crs", 0, crs[0], 0);
        chk("rst_mid_busy", 0, busy[0], 0);
        for (int d = 0; d < 2; d++)
            for (int c = cyc; c < NCYC; c++) begin
                e_crs[d][c] = 1'b0;  e_er[d][c] = 1'b0;  e_busy[d][c] = 1'b0;
                e_done[d][c] = 1'b0; e_ovf[d][c] = 1'b0; e_trunc[d][c] = 1'b0;
                e_rxd[d][c] = 2'b00; e_len[d][c] = 0;
            end
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();

        // recovery after reset
        rand_bytes(3);
        send(0, 1'b0, 1'b1, 1'b1);  wait_idle(0);
        chk("recover_len", 0, len0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
